// File: rtl/sbus_pkg.sv
// rtl/sbus_pkg.sv - shared types and constants for the AXI-Lite to sbus bridge
package sbus_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_COLLECT,
    ST_REQ,
    ST_WAIT_RSP,
    ST_B_RESP,
    ST_R_RESP
  } bridge_state_e;

  // Read data returned when the peripheral never answers.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sbus_timeout_ctr.sv
// rtl/sbus_timeout_ctr.sv - cycle budget counter for bus adapter handshakes
module sbus_timeout_ctr #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] count;

  // Count cycles already spent in the guarded phase; load restarts the budget.
  always_ff @(posedge clk) begin
    if (!reset || load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Flags the last cycle of the budget, so the owner gives up after exactly TIMEOUT cycles.
  assign expired = (TIMEOUT != 0) && enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/axi_lite_sbus_bridge.sv
// rtl/axi_lite_sbus_bridge.sv - AXI4-Lite slave to req/gnt/rvalid peripheral bus bridge
module axi_lite_sbus_bridge
  import sbus_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata,
  input  logic              m_err
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  bridge_state_e state;
  logic          run;
  logic          aw_got, w_got;
  logic          rr_last_wr;
  logic          aw_hs, w_hs, ar_hs;
  logic          tmo_load, tmo_enable, tmo_expired;
  logic          got_rsp, done;
  resp_e         rsp_code;
  logic [31:0]   rsp_data;

  // Accept windows: in IDLE the channel type not served last wins a tie; in
  // W_COLLECT only the missing write half is accepted and reads wait.
  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_arready = 1'b0;
    if (run && state == ST_IDLE) begin
      s_arready = !(s_awvalid || s_wvalid) || rr_last_wr;
      s_awready = !s_arvalid || !rr_last_wr;
      s_wready  = !s_arvalid || !rr_last_wr;
    end else if (state == ST_W_COLLECT) begin
      s_awready = !aw_got;
      s_wready  = !w_got;
    end
  end

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // Budget restarts on entry to REQ and again on entry to WAIT_RSP.
  assign tmo_enable = (state == ST_REQ) || (state == ST_WAIT_RSP);
  assign tmo_load   = !tmo_enable || (state == ST_REQ && m_gnt);

  sbus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .load    (tmo_load),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // A real response beats a timeout landing in the same cycle.
  always_comb begin
    got_rsp  = (state == ST_WAIT_RSP) && m_rvalid;
    done     = got_rsp || (tmo_expired && !(state == ST_REQ && m_gnt));
    rsp_code = got_rsp ? (m_err ? RESP_SLVERR : RESP_OKAY) : RESP_DECERR;
    rsp_data = got_rsp ? m_rdata : TIMEOUT_DATA;
  end

  // Transaction FSM: capture, request, wait for response, hand back to AXI.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      run        <= 1'b0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      rr_last_wr <= 1'b0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_be       <= 4'h0;
      m_addr     <= '0;
      m_wdata    <= 32'h0;
      s_bvalid   <= 1'b0;
      s_bresp    <= RESP_OKAY;
      s_rvalid   <= 1'b0;
      s_rresp    <= RESP_OKAY;
      s_rdata    <= 32'h0;
    end else begin
      run <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            m_addr     <= s_araddr & WORD_MASK;
            m_be       <= 4'hF;
            m_we       <= 1'b0;
            m_req      <= 1'b1;
            rr_last_wr <= 1'b0;
            state      <= ST_REQ;
          end else if (aw_hs || w_hs) begin
            rr_last_wr <= 1'b1;
            m_we       <= 1'b1;
            if (aw_hs) m_addr <= s_awaddr & WORD_MASK;
            if (w_hs) begin
              m_wdata <= s_wdata;
              m_be    <= s_wstrb;
            end
            if (aw_hs && w_hs) begin
              m_req <= 1'b1;
              state <= ST_REQ;
            end else begin
              aw_got <= aw_hs;
              w_got  <= w_hs;
              state  <= ST_W_COLLECT;
            end
          end
        end
        ST_W_COLLECT: begin
          if (aw_hs) begin
            m_addr <= s_awaddr & WORD_MASK;
            aw_got <= 1'b1;
          end
          if (w_hs) begin
            m_wdata <= s_wdata;
            m_be    <= s_wstrb;
            w_got   <= 1'b1;
          end
          if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            m_req  <= 1'b1;
            state  <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT_RSP: begin
          if (state == ST_REQ && m_gnt) begin
            m_req <= 1'b0;
            state <= ST_WAIT_RSP;
          end else if (done) begin
            m_req <= 1'b0;
            if (m_we) begin
              s_bresp  <= rsp_code;
              s_bvalid <= 1'b1;
              state    <= ST_B_RESP;
            end else begin
              s_rresp  <= rsp_code;
              s_rdata  <= rsp_data;
              s_rvalid <= 1'b1;
              state    <= ST_R_RESP;
            end
          end
        end
        ST_B_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_R_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
